// File: rtl/decoder_scoreboard_if.sv
// Issue / writeback / source-read bundle between the pipeline and the scoreboard.
// Latency: none, wires only.
// Backpressure: issue_stall is the only backpressure signal; it goes from slave to master.
interface decoder_scoreboard_if #(
  parameter int ADDR_W = 5
);
  localparam int NREG = 1 << ADDR_W;

  // issue stage
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue_stall;

  // writeback stage
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [NREG-1:0]   wr_onehot;
  logic              spurious_wb;

  // source operand hazard lookup
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              hazard_a;
  logic              hazard_b;

  // scoreboard state
  logic [NREG-1:0]   busy;

  // pipeline side: drives requests and reads status
  modport master (
    output issue_en, issue_addr, wb_en, wb_addr, rd_addr_a, rd_addr_b,
    input  issue_stall, wr_onehot, spurious_wb, hazard_a, hazard_b, busy
  );

  // scoreboard side
  modport slave (
    input  issue_en, issue_addr, wb_en, wb_addr, rd_addr_a, rd_addr_b,
    output issue_stall, wr_onehot, spurious_wb, hazard_a, hazard_b, busy
  );
endinterface

// File: rtl/decoder_scoreboard.sv
// Write-address decoder plus pending-write scoreboard for the register file.
// Latency: issue_stall/hazard_x combinational; busy, wr_onehot, spurious_wb 1 cycle.
// Backpressure: issue_stall refuses an issue to a busy register unless it is written back this cycle.
module decoder_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter bit HAS_ZERO = 1'b1,
  parameter int ZERO_IDX = 31
) (
  input  logic               clk,
  input  logic               reset_n,
  decoder_scoreboard_if.slave bus
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);

  // Bits that may ever be set: everything except the hardwired zero register.
  localparam logic [NREG-1:0] WRITABLE_MASK =
    HAS_ZERO ? ~(NREG'(1) << ZERO_ADDR) : {NREG{1'b1}};

  // True when an address names the hardwired zero register.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return HAS_ZERO && (a == ZERO_ADDR);
  endfunction

  // One-hot decode with the zero register masked to an all-zero vector.
  function automatic logic [NREG-1:0] dec(input logic [ADDR_W-1:0] a);
    logic [NREG-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v & WRITABLE_MASK;
  endfunction

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] wr_onehot_q;
  logic            spurious_q;

  logic [NREG-1:0] clr;
  logic [NREG-1:0] set;
  logic [NREG-1:0] busy_next;
  logic            wb_hits_issue;
  logic            wb_hits_a;
  logic            wb_hits_b;
  logic            stall;
  logic            spurious_next;

  // Same-cycle writeback address matches; a register written this cycle is
  // forwarded through the regfile, so it neither stalls nor hazards.
  always_comb begin
    wb_hits_issue = bus.wb_en && (bus.wb_addr == bus.issue_addr);
    wb_hits_a     = bus.wb_en && (bus.wb_addr == bus.rd_addr_a);
    wb_hits_b     = bus.wb_en && (bus.wb_addr == bus.rd_addr_b);
  end

  // Set/clear vectors and next scoreboard state; set wins over clear so a
  // same-cycle writeback + reissue of one register keeps it busy.
  always_comb begin
    clr           = bus.wb_en ? dec(bus.wb_addr) : '0;
    stall         = bus.issue_en && busy_q[bus.issue_addr] && !wb_hits_issue;
    set           = (bus.issue_en && !stall) ? dec(bus.issue_addr) : '0;
    busy_next     = ((busy_q & ~clr) | set) & WRITABLE_MASK;
    spurious_next = bus.wb_en && !busy_q[bus.wb_addr] && !is_zero(bus.wb_addr);
  end

  // Scoreboard, write-enable and spurious-writeback registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q      <= '0;
      wr_onehot_q <= '0;
      spurious_q  <= 1'b0;
    end else begin
      busy_q      <= busy_next;
      wr_onehot_q <= clr;
      spurious_q  <= spurious_next;
    end
  end

  assign bus.issue_stall = stall;
  assign bus.hazard_a    = busy_q[bus.rd_addr_a] && !wb_hits_a;
  assign bus.hazard_b    = busy_q[bus.rd_addr_b] && !wb_hits_b;
  assign bus.busy        = busy_q;
  assign bus.wr_onehot   = wr_onehot_q;
  assign bus.spurious_wb = spurious_q;

endmodule

// File: tb/tb_decoder_scoreboard.sv
// Bench for decoder_scoreboard: vector table, hand sequences and a writeback sweep.
// Latency: checks comb outputs 1ns after driving, registered outputs 1ns after the edge.
// Backpressure: issue_stall is compared against expected values, never obeyed.
module tb_decoder_scoreboard;
  localparam int ADDR_W = 5;
  localparam int NREG   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  decoder_scoreboard_if #(.ADDR_W(ADDR_W)) sb_if ();

  decoder_scoreboard #(
    .ADDR_W  (ADDR_W),
    .HAS_ZERO(1'b1),
    .ZERO_IDX(31)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (sb_if)
  );

  typedef struct {
    logic              rst_n;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [ADDR_W-1:0] rd_a;
    logic [ADDR_W-1:0] rd_b;
    logic              stall;
    logic              haz_a;
    logic              haz_b;
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   wr;
    logic              sp;
  } vec_t;

  typedef struct {
    logic [NREG-1:0] wr;
    logic            sp;
  } exp_t;

  vec_t vecs[$];
  vec_t seq[$];
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(
    input logic rst_n, input logic ie, input int ia, input logic we, input int wa,
    input int ra, input int rb, input logic st, input logic ha, input logic hb,
    input logic [NREG-1:0] bz, input logic [NREG-1:0] wr, input logic sp);
    vec_t v;
    v.rst_n = rst_n; v.issue_en = ie; v.issue_addr = ADDR_W'(ia);
    v.wb_en = we; v.wb_addr = ADDR_W'(wa);
    v.rd_a = ADDR_W'(ra); v.rd_b = ADDR_W'(rb);
    v.stall = st; v.haz_a = ha; v.haz_b = hb;
    v.busy = bz; v.wr = wr; v.sp = sp;
    return v;
  endfunction

  task automatic check(input string name, input logic [NREG-1:0] act, input logic [NREG-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset_n          = v.rst_n;
    sb_if.issue_en   = v.issue_en;
    sb_if.issue_addr = v.issue_addr;
    sb_if.wb_en      = v.wb_en;
    sb_if.wb_addr    = v.wb_addr;
    sb_if.rd_addr_a  = v.rd_a;
    sb_if.rd_addr_b  = v.rd_b;
  endtask

  // One cycle: drive, check comb outputs, push expectation, clock, pop and check.
  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    drive(v);
    sbq.push_back('{wr: v.wr, sp: v.sp});
    #1;
    check({tag, " issue_stall"}, NREG'(sb_if.issue_stall), NREG'(v.stall));
    check({tag, " hazard_a"},    NREG'(sb_if.hazard_a),    NREG'(v.haz_a));
    check({tag, " hazard_b"},    NREG'(sb_if.hazard_b),    NREG'(v.haz_b));
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check({tag, " wr_onehot"},   sb_if.wr_onehot,          e.wr);
    check({tag, " spurious_wb"}, NREG'(sb_if.spurious_wb), NREG'(e.sp));
    check({tag, " busy"},        sb_if.busy,               v.busy);
  endtask

  initial begin
    //            rst ie ia  we wa  ra  rb  st ha hb  busy          wr            sp
    vecs.push_back(mk(1, 1, 3,  0, 0,  0,  0,  0, 0, 0, 32'h0000_0008, 32'h0,         0));
    vecs.push_back(mk(1, 0, 0,  0, 0,  3,  0,  0, 1, 0, 32'h0000_0008, 32'h0,         0));
    vecs.push_back(mk(1, 1, 3,  0, 0,  3,  0,  1, 1, 0, 32'h0000_0008, 32'h0,         0));
    vecs.push_back(mk(1, 1, 3,  1, 3,  3,  0,  0, 0, 0, 32'h0000_0008, 32'h0000_0008, 0));
    vecs.push_back(mk(1, 1, 7,  0, 0,  0,  0,  0, 0, 0, 32'h0000_0088, 32'h0,         0));
    vecs.push_back(mk(1, 0, 0,  1, 7,  3,  7,  0, 1, 0, 32'h0000_0008, 32'h0000_0080, 0));
    vecs.push_back(mk(1, 0, 0,  1, 12, 12, 0,  0, 0, 0, 32'h0000_0008, 32'h0000_1000, 1));
    vecs.push_back(mk(1, 0, 0,  0, 0,  0,  0,  0, 0, 0, 32'h0000_0008, 32'h0,         0));
    vecs.push_back(mk(1, 1, 31, 0, 0,  31, 0,  0, 0, 0, 32'h0000_0008, 32'h0,         0));
    vecs.push_back(mk(1, 0, 0,  1, 31, 31, 0,  0, 0, 0, 32'h0000_0008, 32'h0,         0));
    vecs.push_back(mk(1, 1, 31, 0, 0,  0,  31, 0, 0, 0, 32'h0000_0008, 32'h0,         0));
    vecs.push_back(mk(1, 1, 1,  0, 0,  0,  0,  0, 0, 0, 32'h0000_000A, 32'h0,         0));
    vecs.push_back(mk(1, 1, 2,  0, 0,  1,  0,  0, 1, 0, 32'h0000_000E, 32'h0,         0));
    vecs.push_back(mk(1, 1, 5,  0, 0,  0,  5,  0, 0, 0, 32'h0000_002E, 32'h0,         0));
    vecs.push_back(mk(1, 0, 0,  1, 3,  1,  5,  0, 1, 1, 32'h0000_0026, 32'h0000_0008, 0));
    vecs.push_back(mk(0, 1, 9,  1, 2,  2,  5,  0, 0, 1, 32'h0,         32'h0,         0));
    vecs.push_back(mk(1, 1, 0,  1, 0,  0,  0,  0, 0, 0, 32'h0000_0001, 32'h0000_0001, 1));
    vecs.push_back(mk(1, 1, 0,  0, 0,  0,  4,  1, 1, 0, 32'h0000_0001, 32'h0,         0));
    vecs.push_back(mk(1, 0, 0,  1, 0,  0,  0,  0, 0, 0, 32'h0,         32'h0000_0001, 0));

    // Back-to-back reissue of r20: allowed only with a same-cycle writeback of r20.
    seq.push_back(mk(1, 1, 20, 0, 0,  20, 0,  0, 0, 0, 32'h0010_0000, 32'h0,         0));
    seq.push_back(mk(1, 1, 20, 1, 20, 20, 20, 0, 0, 0, 32'h0010_0000, 32'h0010_0000, 0));
    seq.push_back(mk(1, 1, 20, 0, 0,  20, 0,  1, 1, 0, 32'h0010_0000, 32'h0,         0));
    seq.push_back(mk(1, 0, 0,  1, 20, 0,  20, 0, 0, 0, 32'h0,         32'h0010_0000, 0));

    // Reset with every other input idle.
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0, '0, 0));
    @(posedge clk);
    #1;
    check("reset busy",        sb_if.busy,               '0);
    check("reset wr_onehot",   sb_if.wr_onehot,          '0);
    check("reset spurious_wb", NREG'(sb_if.spurious_wb), '0);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));
    foreach (seq[i])  run_vec(seq[i],  $sformatf("b2b%0d", i));

    // Writeback sweep with an empty scoreboard: every non-zero register is a
    // spurious writeback and the write enable is a single bit (zero for r31).
    for (int a = 0; a < NREG; a++) begin
      exp_t e;
      logic [NREG-1:0] one;
      one = 1;
      drive(mk(1, 0, 0, 1, a, 0, 0, 0, 0, 0, '0, '0, 0));
      sbq.push_back('{wr: (a == 31) ? '0 : (one << a), sp: (a != 31)});
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      check($sformatf("sweep%0d wr_onehot", a), sb_if.wr_onehot, e.wr);
      check($sformatf("sweep%0d onehot0", a), NREG'($onehot0(sb_if.wr_onehot)), NREG'(1));
      check($sformatf("sweep%0d spurious_wb", a), NREG'(sb_if.spurious_wb), NREG'(e.sp));
    end
    check("sweep busy", sb_if.busy, '0);

    // Idle cycle after the sweep: write enable must drop.
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0, '0, 0));
    @(posedge clk);
    #1;
    check("idle wr_onehot", sb_if.wr_onehot, '0);
    check("idle spurious_wb", NREG'(sb_if.spurious_wb), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
